uart_rx: RTL and testbench

//  8N1 UART receiver; companion to uart_tx on the same serial link.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: baud-period constants shared with uart_tx, receiver FSM states
// and the half-bit helper used to centre sampling inside each bit.
package uart_rx_pkg;

  // Bit period minus one, in clk cycles, for a 100 MHz system clock.
  localparam logic [15:0] B9600   = 16'd10415;
  localparam logic [15:0] B19200  = 16'd5207;
  localparam logic [15:0] B57600  = 16'd1735;
  localparam logic [15:0] B115200 = 16'd867;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Half of a full bit period (BAUDRATE+1 clocks), rounded down.
  function automatic logic [15:0] half_period(input logic [15:0] baudrate);
    logic [16:0] full;
    full = {1'b0, baudrate} + 17'd1;
    return full[16:1];
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous rx pin.
// Both stages reset to 1 so a reset never looks like a start bit.
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the pin through the two synchroniser stages.
  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
  end

  // Synchroniser registers, idle-high after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver. Validates the start bit at half a bit period,
// samples 8 data bits LSB-first at mid-bit, checks the stop bit and hands
// the byte to the consumer through a valid/ack handshake.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [15:0] BAUDRATE = B9600
)
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] HALF_LOAD = half_period(BAUDRATE) - 16'd1;

  logic        rx_s;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        deliver;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .rx_s (rx_s)
  );

  // Next-state logic: bit timing, shifting, stop check and the consumer handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;

    if (ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            cnt_d     = BAUDRATE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = BAUDRATE;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (deliver) begin
      if (!valid_q || ack) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset clears any partial frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx (16 clk/bit) from a
// bit-level sender, plays the consumer side of the handshake and compares
// delivered bytes, error pulses and timing against a frame-level model.
module tb_uart_rx;

  // One clk period is 100 time units; a nominal bit is 1600 units.
  localparam logic [15:0] BAUD    = 16'd15;
  localparam int          NOM_BIT = 1600;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic       ack  = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Consumer and observation state.
  int         ackDelay       = -1;
  int         hold           = 0;
  int         runLen         = 0;
  int         lastValidLen   = 0;
  int         validRises     = 0;
  int         lastRiseCycle  = 0;
  int         frameErrCycles = 0;
  int         busyCycles     = 0;
  int         cycleCount     = 0;
  int         frameStart     = 0;
  logic       prevValid      = 1'b0;
  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];

  uart_rx #(.BAUDRATE(BAUD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .ack       (ack),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #50 clk = ~clk;

  // Free-running cycle count, advanced on the active edge only.
  always @(posedge clk) cycleCount++;

  // Consumer model and observers, sampled half a cycle after the active edge.
  always @(negedge clk) begin : monitor
    logic newAck;
    newAck = valid && (ackDelay >= 0) && (hold >= ackDelay);
    if (valid && newAck) rxQ.push_back(data);
    if (valid && !prevValid) begin
      validRises++;
      lastRiseCycle = cycleCount;
    end
    if (valid) begin
      runLen++;
      hold++;
    end else begin
      if (runLen > 0) lastValidLen = runLen;
      runLen = 0;
      hold   = 0;
    end
    if (frame_err) frameErrCycles++;
    if (busy) busyCycles++;
    prevValid = valid;
    ack       = newAck;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Send one 8N1 frame; the line is left at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input int bitTime, input logic stopVal);
    @(negedge clk);
    frameStart = cycleCount;
    rx = 1'b0;
    #bitTime;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #bitTime;
    end
    rx = stopVal;
    #bitTime;
  endtask

  task automatic idleLine(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b5a;
    logic [7:0] rb;
    int         bt;
    int         expFe;
    int         busyBefore;
    logic       good;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_valid", valid, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rstn = 1'b1;
    idleLine(5);

    // 0xA5, consumer acks 2 clocks after valid.
    ackDelay = 2;
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, NOM_BIT, 1'b1);
    idleLine(20);
    checkOutput("a5_latency", lastRiseCycle - frameStart, 155);
    checkOutput("a5_valid_len", lastValidLen, 3);
    checkOutput("a5_valid_low", valid, 1'b0);
    checkOutput("a5_no_overrun", overrun, 1'b0);
    checkOutput("a5_no_frame_err", frameErrCycles, 0);

    // Back-to-back frames with immediate ack.
    ackDelay = 0;
    expQ.push_back(8'h00);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h55);
    applyStimulus(8'h00, NOM_BIT, 1'b1);
    applyStimulus(8'hFF, NOM_BIT, 1'b1);
    applyStimulus(8'h55, NOM_BIT, 1'b1);
    idleLine(20);
    checkOutput("b2b_rises", validRises, 4);
    checkOutput("b2b_valid_len", lastValidLen, 1);

    // Overrun: second byte arrives while the first is still unacknowledged.
    ackDelay = -1;
    applyStimulus(8'h3C, NOM_BIT, 1'b1);
    idleLine(10);
    checkOutput("ovr_first_valid", valid, 1'b1);
    checkOutput("ovr_first_data", data, 8'h3C);
    applyStimulus(8'hC3, NOM_BIT, 1'b1);
    idleLine(10);
    checkOutput("ovr_data_kept", data, 8'h3C);
    checkOutput("ovr_valid_held", valid, 1'b1);
    checkOutput("ovr_flag", overrun, 1'b1);
    expQ.push_back(8'h3C);
    ackDelay = 0;
    repeat (3) @(negedge clk);
    checkOutput("ovr_ack_valid", valid, 1'b0);
    checkOutput("ovr_ack_clear", overrun, 1'b0);

    // Stop bit forced low; line stays low as a break.
    applyStimulus(8'h81, NOM_BIT, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("fe_pulse_width", frameErrCycles, 1);
    checkOutput("fe_valid_low", valid, 1'b0);
    checkOutput("fe_break_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("fe_break_exit", busy, 1'b0);
    checkOutput("fe_no_delivery", validRises, 5);

    // Short low glitch on an idle line.
    busyBefore = busyCycles;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_cycles", busyCycles - busyBefore, 8);
    checkOutput("glitch_no_valid", validRises, 5);
    checkOutput("glitch_no_fe", frameErrCycles, 1);

    // Reset in the middle of 0x5A, then a clean 0x12.
    b5a = 8'h5A;
    @(negedge clk);
    rx = 1'b0;
    #NOM_BIT;
    for (int i = 0; i < 4; i++) begin
      rx = b5a[i];
      #NOM_BIT;
    end
    @(negedge clk);
    rstn = 1'b0;
    rx   = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_valid", valid, 1'b0);
    checkOutput("midrst_data", data, 8'h00);
    rstn = 1'b1;
    idleLine(20);
    expQ.push_back(8'h12);
    applyStimulus(8'h12, NOM_BIT, 1'b1);
    idleLine(20);
    checkOutput("midrst_rises", validRises, 6);

    // Sender 4% fast and 4% slow.
    expQ.push_back(8'h96);
    expQ.push_back(8'h96);
    applyStimulus(8'h96, 1536, 1'b1);
    idleLine(20);
    applyStimulus(8'h96, 1664, 1'b1);
    idleLine(20);
    checkOutput("tol_rises", validRises, 8);

    // Random frames: random byte, rate within tolerance, stop-bit error, ack delay.
    expFe = 1;
    for (int n = 0; n < 24; n++) begin
      rb       = 8'($urandom_range(0, 255));
      bt       = 1540 + 20 * int'($urandom_range(0, 6));
      good     = ($urandom_range(0, 4) != 0);
      ackDelay = int'($urandom_range(0, 5));
      if (good) expQ.push_back(rb);
      else expFe++;
      applyStimulus(rb, bt, good);
      idleLine(good ? int'($urandom_range(0, 20)) : 40);
    end
    idleLine(40);
    checkOutput("rand_frame_errs", frameErrCycles, expFe);
    checkOutput("final_valid_low", valid, 1'b0);

    // Every delivered byte, in order, against the frame-level model.
    checkOutput("rx_count", rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      checkOutput($sformatf("byte_%0d", i), rxQ[i], expQ[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
